// File: rtl/blk_2d3064.sv
// 64-entry demultiplexed register file: single-entry writes selected by SELECT,
// plus a one-entry-per-cycle clear sweep that blocks writes while it runs.
module blk_2d3064 #(
    parameter int BITS = 32
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [BITS-1:0]          DATA_IN,
    input  logic [5:0]               SELECT,
    input  logic                     WRITE_VALID,
    input  logic                     CLEAR_REQ,
    output logic                     WRITE_READY,
    output logic [63:0][BITS-1:0]    DATA_OUT,
    output logic [63:0]              ENTRY_VALID,
    output logic                     BUSY,
    output logic                     CLEAR_DONE,
    output logic                     OVERWRITE
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t                  r_state;
    logic [5:0]              r_sweepIdx;
    logic                    r_clearDone;
    logic                    r_overwrite;
    logic [63:0][BITS-1:0]   r_data;
    logic [63:0]             r_valid;

    logic                    w_idle;
    logic                    w_writeAccept;
    logic [63:0]             w_writeEn;
    logic [63:0]             w_clearEn;

    assign w_idle        = (r_state == IDLE);
    assign w_writeAccept = WRITE_VALID & w_idle;

    // One-hot enables; write and clear are mutually exclusive because they depend on opposite states.
    assign w_writeEn = w_writeAccept ? (64'd1 << SELECT) : 64'd0;
    assign w_clearEn = w_idle ? 64'd0 : (64'd1 << r_sweepIdx);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state     <= IDLE;
            r_sweepIdx  <= 6'd0;
            r_clearDone <= 1'b0;
            r_overwrite <= 1'b0;
        end else begin
            r_clearDone <= 1'b0;
            r_overwrite <= w_writeAccept & r_valid[SELECT];
            case (r_state)
                IDLE: begin
                    if (CLEAR_REQ) begin
                        r_state    <= CLEAR;
                        r_sweepIdx <= 6'd0;
                    end
                end
                CLEAR: begin
                    r_sweepIdx <= r_sweepIdx + 6'd1;
                    if (r_sweepIdx == 6'd63) begin
                        r_state     <= IDLE;
                        r_clearDone <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_data  <= '0;
            r_valid <= 64'd0;
        end else begin
            r_valid <= (r_valid & ~w_clearEn) | w_writeEn;
            for (int k = 0; k < 64; k++) begin
                if (w_clearEn[k]) begin
                    r_data[k] <= '0;
                end else if (w_writeEn[k]) begin
                    r_data[k] <= DATA_IN;
                end
            end
        end
    end

    assign WRITE_READY = w_idle;
    assign BUSY        = ~w_idle;
    assign CLEAR_DONE  = r_clearDone;
    assign OVERWRITE   = r_overwrite;
    assign DATA_OUT    = r_data;
    assign ENTRY_VALID = r_valid;

endmodule
